aes128_iter_ctrl: RTL and testbench



---
 rtl/aes_pkg.sv | 90 +++++++++
 rtl/aes_final_round.sv | 21 ++
 rtl/aes_key_step.sv | 32 +++
 rtl/aes_round.sv | 21 ++
 rtl/aes_sbox.sv | 11 +
 rtl/aes128_iter_ctrl.sv | 117 +++++++++++
 tb/tb_aes128_iter_ctrl.sv | 236 +++++++++++++++++++++++
 7 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and byte-level transform helpers.
package aes_pkg;

    localparam int unsigned NR_AES128 = 10;
    localparam int unsigned BLK_W     = 128;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned NUM_BYTES = 16;
    localparam int unsigned RND_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // Round constants for rounds 1..10, first round in the top byte.
    localparam logic [79:0] RCON = 80'h01020408102040801b36;

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [BYTE_W-1:0] sbox_lut(input logic [BYTE_W-1:0] a);
        return SBOX[{~a, 3'b000} +: 8];
    endfunction

    function automatic logic [BYTE_W-1:0] rcon_lut(input logic [RND_W-1:0] rnd);
        logic [BYTE_W-1:0] r;
        r = '0;
        if (rnd >= RND_W'(1) && rnd <= RND_W'(NR_AES128)) begin
            r = RCON[8*(NR_AES128 - 32'(rnd)) +: 8];
        end
        return r;
    endfunction

    // Byte i of the state (column-major, byte 0 at the MSB) sits at this LSB.
    function automatic int unsigned byte_lsb(input int unsigned i);
        return BLK_W - BYTE_W * (i + 1);
    endfunction

    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned rw = 0; rw < 4; rw++) begin
                r[byte_lsb(4*c + rw) +: 8] = s[byte_lsb(4*((c + rw) % 4) + rw) +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0]  r;
        logic [BYTE_W-1:0] a0, a1, a2, a3;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[byte_lsb(4*c + 0) +: 8];
            a1 = s[byte_lsb(4*c + 1) +: 8];
            a2 = s[byte_lsb(4*c + 2) +: 8];
            a3 = s[byte_lsb(4*c + 3) +: 8];
            r[byte_lsb(4*c + 0) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[byte_lsb(4*c + 1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[byte_lsb(4*c + 2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[byte_lsb(4*c + 3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_final_round.sv
// Last AES round: SubBytes, ShiftRows, AddRoundKey (MixColumns is skipped).
module aes_final_round
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] state_i,
    input  logic [BLK_W-1:0] key_i,
    output logic [BLK_W-1:0] state_o
);

    logic [BLK_W-1:0] sub;

    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_sbox
        aes_sbox u_sbox (
            .a_i (state_i[8*i +: 8]),
            .y_o (sub[8*i +: 8])
        );
    end

    assign state_o = shift_rows(sub) ^ key_i;

endmodule

// File: rtl/aes_key_step.sv
// One step of the AES-128 key schedule: next round key from current key and rcon.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0]  key_i,
    input  logic [BYTE_W-1:0] rcon_i,
    output logic [BLK_W-1:0]  key_o
);

    logic [WORD_W-1:0] w0, w1, w2, w3;
    logic [WORD_W-1:0] rot, sub, tmp;
    logic [WORD_W-1:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key_i;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .a_i (rot[8*i +: 8]),
            .y_o (sub[8*i +: 8])
        );
    end

    assign tmp = sub ^ {rcon_i, 24'h000000};
    assign n0  = w0 ^ tmp;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;

    assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round.sv
// Full AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] state_i,
    input  logic [BLK_W-1:0] key_i,
    output logic [BLK_W-1:0] state_o
);

    logic [BLK_W-1:0] sub;

    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_sbox
        aes_sbox u_sbox (
            .a_i (state_i[8*i +: 8]),
            .y_o (sub[8*i +: 8])
        );
    end

    assign state_o = mix_columns(shift_rows(sub)) ^ key_i;

endmodule

// File: rtl/aes_sbox.sv
// Single-byte AES forward S-box.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] a_i,
    output logic [BYTE_W-1:0] y_o
);

    assign y_o = sbox_lut(a_i);

endmodule

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: one round per clock over a shared round datapath,
// round keys expanded on the fly, result held on a valid/ready output.
module aes128_iter_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BLK_W-1:0]  in_data,
    input  logic [BLK_W-1:0]  in_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BLK_W-1:0]  out_data,
    output logic              busy
);

    if (NR != NR_AES128) begin : g_nr_check
        $error("aes128_iter_ctrl: NR must be 10");
    end

    fsm_e             fsm_q, fsm_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [BLK_W-1:0] rk_q, rk_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [BLK_W-1:0] rk_next;
    logic [BLK_W-1:0] round_out;
    logic [BLK_W-1:0] final_out;

    aes_key_step u_key_step (
        .key_i  (rk_q),
        .rcon_i (rcon_lut(rnd_q)),
        .key_o  (rk_next)
    );

    aes_round u_round (
        .state_i (blk_q),
        .key_i   (rk_next),
        .state_o (round_out)
    );

    aes_final_round u_final (
        .state_i (blk_q),
        .key_i   (rk_next),
        .state_o (final_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            blk_q       <= '0;
            rk_q        <= '0;
            rnd_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            blk_q       <= blk_d;
            rk_q        <= rk_d;
            rnd_q       <= rnd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Handshake flags are registered from the next state so they track fsm_q exactly.
    always_comb begin
        fsm_d = fsm_q;
        blk_d = blk_q;
        rk_d  = rk_q;
        rnd_d = rnd_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    blk_d = in_data ^ in_key;
                    rk_d  = in_key;
                    rnd_d = RND_W'(1);
                    fsm_d = RUN;
                end
            end
            RUN: begin
                rk_d = rk_next;
                if (rnd_q == RND_W'(NR)) begin
                    blk_d = final_out;
                    rnd_d = '0;
                    fsm_d = DONE;
                end else begin
                    blk_d = round_out;
                    rnd_d = rnd_q + RND_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
        in_ready_d  = (fsm_d == IDLE);
        out_valid_d = (fsm_d == DONE);
        busy_d      = (fsm_d != IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = blk_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Directed known-answer bench for aes128_iter_ctrl.
module tb_aes128_iter_ctrl;

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK1_B = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] C_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int checks;
    int errors;
    int cyc;
    int t0;

    aes128_iter_ctrl #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkint(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input string tag, input logic [127:0] pt, input logic [127:0] key);
        chk1({tag, "_rdy_before"}, in_ready, 1'b1);
        in_data  = pt;
        in_key   = key;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        t0 = cyc;
        chk1({tag, "_busy"}, busy, 1'b1);
        chk1({tag, "_rdy_low"}, in_ready, 1'b0);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk1({tag, "_valid_seen"}, out_valid, 1'b1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        t0        = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b1;
        #12;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk128("rst_out_data", out_data, 128'h0);
        rst = 1'b0;
        step();

        // FIPS-197 C.1 with a consumer that is always ready
        accept("c1", P_C1, K_C1);
        wait_valid("c1");
        chkint("c1_latency", cyc - t0, 10);
        chk128("c1_ct", out_data, C_C1);
        step();
        chk1("c1_out_valid_drop", out_valid, 1'b0);
        chk1("c1_in_ready_back", in_ready, 1'b1);
        chk1("c1_busy_drop", busy, 1'b0);

        // Appendix B, including the first expanded round key
        accept("b", P_B, K_B);
        step();
        chk128("b_rk1", dut.rk_q, RK1_B);
        wait_valid("b");
        chkint("b_latency", cyc - t0, 10);
        chk128("b_ct", out_data, C_B);
        step();
        chk1("b_in_ready_back", in_ready, 1'b1);

        // All-zero block with backpressure and stray in_valid pulses
        out_ready = 1'b0;
        accept("z", 128'h0, 128'h0);
        step();
        in_data  = P_C1;
        in_key   = K_C1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk1("z_run_rdy", in_ready, 1'b0);
        wait_valid("z");
        chkint("z_latency", cyc - t0, 10);
        chk128("z_ct", out_data, C_Z);
        in_data  = P_B;
        in_key   = K_B;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk1("z_hold_valid", out_valid, 1'b1);
            chk128("z_hold_data", out_data, C_Z);
            chk1("z_hold_rdy", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk1("z_out_valid_drop", out_valid, 1'b0);
        chk1("z_in_ready_back", in_ready, 1'b1);
        chk1("z_busy_drop", busy, 1'b0);

        // Back-to-back with in_valid held high throughout
        in_data  = P_C1;
        in_key   = K_C1;
        in_valid = 1'b1;
        step();
        t0 = cyc;
        chk1("bb1_busy", busy, 1'b1);
        in_data = P_B;
        in_key  = K_B;
        wait_valid("bb1");
        chkint("bb1_latency", cyc - t0, 10);
        chk128("bb1_ct", out_data, C_C1);
        step();
        chk1("bb_handshake_valid", out_valid, 1'b0);
        chk1("bb_handshake_rdy", in_ready, 1'b1);
        step();
        chk1("bb2_busy", busy, 1'b1);
        chkint("bb2_accept_gap", cyc - t0, 12);
        in_valid = 1'b0;
        t0 = cyc;
        wait_valid("bb2");
        chkint("bb2_latency", cyc - t0, 10);
        chk128("bb2_ct", out_data, C_B);
        step();
        chk1("bb2_in_ready_back", in_ready, 1'b1);

        // Asynchronous reset in the middle of a run
        accept("rs", P_C1, K_C1);
        repeat (4) step();
        #3;
        rst = 1'b1;
        #1;
        chk1("rs_out_valid", out_valid, 1'b0);
        chk1("rs_in_ready", in_ready, 1'b1);
        chk1("rs_busy", busy, 1'b0);
        chk128("rs_out_data", out_data, 128'h0);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk1("rs_no_pulse", out_valid, 1'b0);
        end
        accept("rsb", P_B, K_B);
        wait_valid("rsb");
        chkint("rsb_latency", cyc - t0, 10);
        chk128("rsb_ct", out_data, C_B);
        step();

        // Inputs scrambled every cycle after acceptance
        accept("hd", P_C1, K_C1);
        for (int k = 0; k < 9; k++) begin
            in_data = {16{8'(k + 1)}};
            in_key  = ~in_data;
            step();
        end
        wait_valid("hd");
        chkint("hd_latency", cyc - t0, 10);
        chk128("hd_ct", out_data, C_C1);
        step();
        chk1("hd_in_ready_back", in_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
